// File: rtl/uart_aes_pkg.sv
// rtl/uart_aes_pkg.sv - opcodes, buffer selects, command constants and FSM states for uart_cmd_ctrl
package uart_aes_pkg;

  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CTRL  = 2'b11;

  localparam logic [1:0] SEL_KEY   = 2'b00;
  localparam logic [1:0] SEL_NONCE = 2'b01;
  localparam logic [1:0] SEL_DIN   = 2'b10;

  localparam logic [1:0] RD_RESULT = 2'b00;
  localparam logic [1:0] RD_STATUS = 2'b01;

  localparam logic [7:0] CMD_START = 8'hC0;
  localparam logic [7:0] CMD_CLEAR = 8'hC1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_SEND,
    ST_START
  } cmd_state_t;

  // Byte index 0 is the most significant byte; ~idx equals 15-idx for a 4-bit index.
  function automatic logic [7:0] byte_at(input logic [127:0] v, input logic [3:0] idx);
    return v[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - UART byte streams and AES core signals of uart_cmd_ctrl
interface uart_cmd_ctrl_if;

  logic [7:0]   rx_data_i;
  logic         rx_valid_i;
  logic         rx_ready_o;
  logic [7:0]   tx_data_o;
  logic         tx_valid_o;
  logic         tx_ready_i;
  logic [127:0] key_o;
  logic [127:0] nonce_o;
  logic [127:0] din_o;
  logic         start_o;
  logic         busy_i;
  logic [127:0] dout_i;
  logic         dout_valid_i;

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i, busy_i, dout_i, dout_valid_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, key_o, nonce_o, din_o, start_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i, busy_i, dout_i, dout_valid_i,
    output rx_ready_o, tx_data_o, tx_valid_o, key_o, nonce_o, din_o, start_o
  );

endinterface

// File: rtl/aes_byte_buf.sv
// rtl/aes_byte_buf.sv - 128-bit buffer with indexed byte write and synchronous clear
module aes_byte_buf (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [3:0]   idx,
  input  logic [7:0]   wdata,
  input  logic         clr,
  output logic [127:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q[{~idx, 3'b000} +: 8] <= wdata;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART command decoder feeding the AES core and returning results/status
// Optional WAIT_DATA timeout built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl
  import uart_aes_pkg::*;
`ifdef UART_CMD_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
)
`endif
(
  input  logic            clk_i,
  input  logic            rst_i,
  uart_cmd_ctrl_if.slave  bus
);

  cmd_state_t state_q, state_d;

  logic [1:0]   op;
  logic [1:0]   sel;
  logic         rx_ready;
  logic         xfer;
  logic         tx_load;
  logic         rd_inc;
  logic [7:0]   tx_byte;
  logic         buf_clr;
  logic [2:0]   buf_we;
  logic [1:0]   sel_q;
  logic [3:0]   addr_q;
  logic [7:0]   tx_data_q;
  logic [127:0] res_q;
  logic [3:0]   rd_ptr_q;
  logic         done_q;
  logic         timeout;

  assign op  = bus.rx_data_i[7:6];
  assign sel = bus.rx_data_i[5:4];

  // Gated by rst_i so ready is low for the whole reset, not only after it.
  assign rx_ready = ~rst_i & ((state_q == ST_IDLE) || (state_q == ST_WAIT_DATA));
  assign xfer     = bus.rx_valid_i & rx_ready;

  assign bus.rx_ready_o = rx_ready;
  assign bus.tx_valid_o = (state_q == ST_SEND);
  assign bus.tx_data_o  = tx_data_q;
  assign bus.start_o    = (state_q == ST_START);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if ((state_d != state_q) || (state_q != ST_WAIT_DATA)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    tx_byte = 8'h00;
    case (sel)
      RD_RESULT: tx_byte = byte_at(res_q, rd_ptr_q);
      RD_STATUS: tx_byte = {6'b0, done_q, bus.busy_i};
      default:   tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tx_load = 1'b0;
    rd_inc  = 1'b0;
    buf_clr = 1'b0;
    buf_we  = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          case (op)
            OP_WRITE: state_d = ST_WAIT_DATA;
            OP_READ: begin
              state_d = ST_SEND;
              tx_load = 1'b1;
              rd_inc  = (sel == RD_RESULT);
            end
            OP_CTRL: begin
              if (bus.rx_data_i == CMD_START && !bus.busy_i) begin
                state_d = ST_START;
              end else if (bus.rx_data_i == CMD_CLEAR) begin
                buf_clr = 1'b1;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_WAIT_DATA: begin
        if (xfer) begin
          state_d = ST_IDLE;
          if (!bus.busy_i) begin
            case (sel_q)
              SEL_KEY:   buf_we = 3'b001;
              SEL_NONCE: buf_we = 3'b010;
              SEL_DIN:   buf_we = 3'b100;
              default:   buf_we = 3'b000;
            endcase
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (bus.tx_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q     <= '0;
      addr_q    <= '0;
      tx_data_q <= '0;
      res_q     <= '0;
      rd_ptr_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && xfer) begin
        sel_q  <= sel;
        addr_q <= bus.rx_data_i[3:0];
      end
      if (tx_load) begin
        tx_data_q <= tx_byte;
      end
      if (rd_inc) begin
        rd_ptr_q <= rd_ptr_q + 4'd1;
      end
      if (state_q == ST_START) begin
        done_q <= 1'b0;
      end
      // A new result overrides any read-pointer advance in the same cycle.
      if (bus.dout_valid_i) begin
        res_q    <= bus.dout_i;
        done_q   <= 1'b1;
        rd_ptr_q <= '0;
      end
    end
  end

  aes_byte_buf u_key_buf (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (buf_we[0]),
    .idx   (addr_q),
    .wdata (bus.rx_data_i),
    .clr   (buf_clr),
    .q     (bus.key_o)
  );

  aes_byte_buf u_nonce_buf (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (buf_we[1]),
    .idx   (addr_q),
    .wdata (bus.rx_data_i),
    .clr   (buf_clr),
    .q     (bus.nonce_o)
  );

  aes_byte_buf u_din_buf (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (buf_we[2]),
    .idx   (addr_q),
    .wdata (bus.rx_data_i),
    .clr   (buf_clr),
    .q     (bus.din_o)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  import uart_aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  uart_cmd_ctrl_if ifc ();

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
`else
  uart_cmd_ctrl dut (
`endif
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (ifc.rx_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL send_wait: rx_ready_o=%b required 1 for byte %h", ifc.rx_ready_o, b);
    end
    ifc.rx_data_i  = b;
    ifc.rx_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.rx_valid_i = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] exp, input string name);
    int n;
    n = 0;
    while (ifc.tx_valid_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ifc.tx_valid_o !== 1'b1 || ifc.tx_data_o !== exp)
      $display("FAIL %s: tx_valid=%b tx_data=%h required valid=1 data=%h", name, ifc.tx_valid_o, ifc.tx_data_o, exp);
    else
      passed++;
    ifc.tx_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.tx_ready_i = 1'b0;
  endtask

  task automatic pulse_dout(input logic [127:0] v);
    ifc.dout_i       = v;
    ifc.dout_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifc.dout_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if (ifc.rx_ready_o !== 1'b0 || ifc.tx_valid_o !== 1'b0 || ifc.tx_data_o !== 8'h00 || ifc.start_o !== 1'b0)
      $display("FAIL reset_ctrl: rx_ready=%b tx_valid=%b tx_data=%h start=%b required 0/0/00/0",
               ifc.rx_ready_o, ifc.tx_valid_o, ifc.tx_data_o, ifc.start_o);
    else passed++;
    total++;
    if (ifc.key_o !== '0 || ifc.nonce_o !== '0 || ifc.din_o !== '0)
      $display("FAIL reset_bufs: key=%h nonce=%h din=%h required all 0", ifc.key_o, ifc.nonce_o, ifc.din_o);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ifc.rx_ready_o !== 1'b1)
      $display("FAIL reset_release_ready: rx_ready=%b required 1", ifc.rx_ready_o);
    else passed++;
  endtask

  task automatic test_write;
    send_byte(8'h80);
    send_byte(8'h2B);
    total++;
    if (ifc.key_o !== {8'h2B, 120'h0})
      $display("FAIL write_key_msb: key=%h required %h", ifc.key_o, {8'h2B, 120'h0});
    else passed++;
    send_byte(8'h8F);
    send_byte(8'h3C);
    total++;
    if (ifc.key_o !== {8'h2B, 112'h0, 8'h3C})
      $display("FAIL write_key_lsb: key=%h required %h", ifc.key_o, {8'h2B, 112'h0, 8'h3C});
    else passed++;
    total++;
    if (ifc.nonce_o !== '0 || ifc.din_o !== '0)
      $display("FAIL write_others: nonce=%h din=%h required 0", ifc.nonce_o, ifc.din_o);
    else passed++;
  endtask

  task automatic test_write_all_start;
    logic [127:0] k_exp = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] n_exp = 128'h404142434445464748494A4B4C4D4E4F;
    logic [127:0] d_exp = 128'h808182838485868788898A8B8C8D8E8F;
    logic seen;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h80 | 8'(i));
      send_byte(8'(i));
      send_byte(8'h90 | 8'(i));
      send_byte(8'h40 + 8'(i));
      send_byte(8'hA0 | 8'(i));
      send_byte(8'h80 + 8'(i));
    end
    total++;
    if (ifc.key_o !== k_exp || ifc.nonce_o !== n_exp || ifc.din_o !== d_exp)
      $display("FAIL write_all: key=%h nonce=%h din=%h required %h %h %h",
               ifc.key_o, ifc.nonce_o, ifc.din_o, k_exp, n_exp, d_exp);
    else passed++;
    ifc.busy_i = 1'b1;
    send_byte(8'h80);
    send_byte(8'hFF);
    send_byte(8'hB3);
    send_byte(8'h77);
    ifc.busy_i = 1'b0;
    total++;
    if (ifc.key_o !== k_exp || ifc.nonce_o !== n_exp || ifc.din_o !== d_exp)
      $display("FAIL write_dropped: key=%h nonce=%h din=%h required unchanged", ifc.key_o, ifc.nonce_o, ifc.din_o);
    else passed++;
    send_byte(CMD_START);
    total++;
    if (ifc.start_o !== 1'b1)
      $display("FAIL start_pulse: start=%b required 1", ifc.start_o);
    else passed++;
    @(negedge clk);
    total++;
    if (ifc.start_o !== 1'b0)
      $display("FAIL start_one_cycle: start=%b required 0", ifc.start_o);
    else passed++;
    ifc.busy_i = 1'b1;
    send_byte(CMD_START);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ifc.start_o !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    ifc.busy_i = 1'b0;
    total++;
    if (seen)
      $display("FAIL start_busy: start pulsed=1 required 0");
    else passed++;
    send_byte(CMD_CLEAR);
    total++;
    if (ifc.key_o !== '0 || ifc.nonce_o !== '0 || ifc.din_o !== '0)
      $display("FAIL clear: key=%h nonce=%h din=%h required 0", ifc.key_o, ifc.nonce_o, ifc.din_o);
    else passed++;
  endtask

  task automatic test_read;
    pulse_dout(128'h00112233445566778899AABBCCDDEEFF);
    send_byte(8'h40);
    total++;
    if (ifc.tx_valid_o !== 1'b1 || ifc.rx_ready_o !== 1'b0)
      $display("FAIL read_latency: tx_valid=%b rx_ready=%b required 1/0", ifc.tx_valid_o, ifc.rx_ready_o);
    else passed++;
    recv_byte(8'h00, "read_byte0");
    for (int i = 1; i < 16; i++) begin
      send_byte(8'h40);
      recv_byte(8'(i * 8'h11), "read_byte");
    end
    send_byte(8'h40);
    recv_byte(8'h00, "read_wrap");
    send_byte(8'h40);
    recv_byte(8'h11, "read_after_wrap");
    pulse_dout(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    send_byte(8'h40);
    recv_byte(8'hA0, "read_ptr_reset");
    send_byte(8'h40);
    recv_byte(8'hA1, "read_new_next");
  endtask

  task automatic test_status;
    ifc.busy_i = 1'b1;
    send_byte(8'h50);
    recv_byte(8'h03, "status_done_busy");
    ifc.busy_i = 1'b0;
    send_byte(8'h50);
    recv_byte(8'h02, "status_done_idle");
    send_byte(CMD_START);
    send_byte(8'h50);
    recv_byte(8'h00, "status_after_start");
    send_byte(8'h60);
    recv_byte(8'h00, "read_sel2");
    send_byte(8'h70);
    recv_byte(8'h00, "read_sel3");
  endtask

  task automatic test_ignored;
    send_byte(8'h2A);
    send_byte(8'hC5);
    total++;
    if (ifc.tx_valid_o !== 1'b0 || ifc.start_o !== 1'b0 || ifc.rx_ready_o !== 1'b1)
      $display("FAIL ignored_ops: tx_valid=%b start=%b rx_ready=%b required 0/0/1",
               ifc.tx_valid_o, ifc.start_o, ifc.rx_ready_o);
    else passed++;
  endtask

  task automatic test_hold_and_reset;
    logic bad;
    bad = 1'b0;
    send_byte(8'h40);
    for (int i = 0; i < 50; i++) begin
      if (ifc.tx_valid_o !== 1'b1 || ifc.tx_data_o !== 8'hA2 || ifc.rx_ready_o !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    total++;
    if (bad)
      $display("FAIL hold_send: tx_valid=%b tx_data=%h rx_ready=%b required 1/a2/0 for 50 cycles",
               ifc.tx_valid_o, ifc.tx_data_o, ifc.rx_ready_o);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (ifc.tx_valid_o !== 1'b0 || ifc.tx_data_o !== 8'h00 || ifc.rx_ready_o !== 1'b0)
      $display("FAIL reset_midsend: tx_valid=%b tx_data=%h rx_ready=%b required 0/00/0",
               ifc.tx_valid_o, ifc.tx_data_o, ifc.rx_ready_o);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h40);
    recv_byte(8'h00, "result_cleared_by_reset");
  endtask

`ifdef UART_CMD_TIMEOUT_EN
  task automatic test_timeout;
    send_byte(8'h90);
    repeat (20) @(negedge clk);
    send_byte(8'h40);
    total++;
    if (ifc.tx_valid_o !== 1'b1)
      $display("FAIL timeout_read: tx_valid=%b required 1", ifc.tx_valid_o);
    else passed++;
    recv_byte(8'h00, "timeout_read_data");
    total++;
    if (ifc.nonce_o !== '0)
      $display("FAIL timeout_nonce: nonce=%h required 0", ifc.nonce_o);
    else passed++;
  endtask
`endif

  initial begin
    ifc.rx_data_i    = 8'h00;
    ifc.rx_valid_i   = 1'b0;
    ifc.tx_ready_i   = 1'b0;
    ifc.busy_i       = 1'b0;
    ifc.dout_i       = '0;
    ifc.dout_valid_i = 1'b0;
    test_reset();
    test_write();
    test_write_all_start();
    test_read();
    test_status();
    test_ignored();
    test_hold_and_reset();
`ifdef UART_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
